// File: rtl/ncl_dualrail_rx.sv
// ncl_dualrail_rx: clocked receiver terminating a dual-rail four-phase NCL pipeline.
// Synchronizes the rails, detects DATA/NULL wavefronts, returns completion on acomp,
// and delivers each decoded DATA word through a small valid/ready output FIFO.
module ncl_dualrail_rx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 2
) (
  input  logic               clk,
  input  logic               init,
  input  logic [2*WIDTH-1:0] a,
  output logic               acomp,
  output logic [WIDTH-1:0]   dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               err,
  output logic [15:0]        word_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE_NULL = 2'd0,
    WAIT_NULL = 2'd1,
    ERROR     = 2'd2
  } state_t;

  // ---------------------------------------------------------------
  // Rail synchronizers
  // ---------------------------------------------------------------
  logic [2*WIDTH-1:0] sync_reg [SYNC_STAGES];
  logic [2*WIDTH-1:0] s;

  // First stage samples the asynchronous rails directly.
  always_ff @(posedge clk) begin
    if (init) sync_reg[0] <= '0;
    else      sync_reg[0] <= a;
  end

  genvar gi;
  generate
    for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      // Remaining stages shift the sampled rails toward s.
      always_ff @(posedge clk) begin
        if (init) sync_reg[gi] <= '0;
        else      sync_reg[gi] <= sync_reg[gi-1];
      end
    end
  endgenerate

  assign s = sync_reg[SYNC_STAGES-1];

  // ---------------------------------------------------------------
  // Wavefront classification on the synchronized rails
  // ---------------------------------------------------------------
  logic [WIDTH-1:0] bit_null;
  logic [WIDTH-1:0] bit_data;
  logic [WIDTH-1:0] bit_ill;
  logic [WIDTH-1:0] word_dec;

  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cls
      assign bit_null[gi] = ~s[2*gi+1] & ~s[2*gi];
      assign bit_data[gi] =  s[2*gi+1] ^  s[2*gi];
      assign bit_ill[gi]  =  s[2*gi+1] &  s[2*gi];
      assign word_dec[gi] =  s[2*gi+1];
    end
  endgenerate

  logic is_null;
  logic is_data;
  logic is_ill;

  assign is_null = &bit_null;
  assign is_data = &bit_data;
  assign is_ill  = |bit_ill;

  // ---------------------------------------------------------------
  // Output FIFO state
  // ---------------------------------------------------------------
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic [WIDTH-1:0] dout_reg;
  logic [WIDTH-1:0] dout_next;
  logic             dout_valid_reg;
  logic             full;
  logic             push;
  logic             pop;
  state_t           state_reg;

  assign full = (count_reg == CW'(DEPTH));
  assign pop  = dout_valid_reg & dout_ready;

  // Push only on a clean DATA wavefront while waiting for DATA; an illegal
  // code in the same cycle wins, and a full FIFO (before any pop) refuses.
  always_comb begin
    push = 1'b0;
    if (state_reg == IDLE_NULL && is_data && !is_ill && !full) push = 1'b1;
  end

  // Next occupancy and next head word; the head register keeps the last
  // word when the FIFO runs empty.
  always_comb begin
    count_next = count_reg + CW'(push) - CW'(pop);
    dout_next  = dout_reg;
    if (pop) begin
      if (count_reg > CW'(1))
        dout_next = mem[rd_ptr_reg + AW'(1)];
      else if (push)
        dout_next = word_dec;
    end else if (push && count_reg == '0) begin
      dout_next = word_dec;
    end
  end

  // Storage array write port; contents need no reset since the head is
  // tracked in its own register.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= word_dec;
  end

  // FIFO pointers, occupancy and registered head/valid.
  always_ff @(posedge clk) begin
    if (init) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg      <= count_next;
      dout_reg       <= dout_next;
      dout_valid_reg <= (count_next != '0);
    end
  end

  // ---------------------------------------------------------------
  // Handshake FSM with registered acomp, err and word counter
  // ---------------------------------------------------------------
  logic        acomp_reg;
  logic        err_reg;
  logic [15:0] word_cnt_reg;

  // Illegal codes trap into ERROR from any state; otherwise alternate
  // between accepting one DATA word and waiting for the NULL return.
  always_ff @(posedge clk) begin
    if (init) begin
      state_reg    <= IDLE_NULL;
      acomp_reg    <= 1'b0;
      err_reg      <= 1'b0;
      word_cnt_reg <= '0;
    end else if (is_ill) begin
      state_reg <= ERROR;
      acomp_reg <= 1'b0;
      err_reg   <= 1'b1;
    end else begin
      case (state_reg)
        IDLE_NULL: begin
          if (push) begin
            state_reg    <= WAIT_NULL;
            acomp_reg    <= 1'b1;
            word_cnt_reg <= word_cnt_reg + 16'd1;
          end
        end
        WAIT_NULL: begin
          if (is_null) begin
            state_reg <= IDLE_NULL;
            acomp_reg <= 1'b0;
          end
        end
        ERROR: begin
          acomp_reg <= 1'b0;
        end
        default: begin
          state_reg <= ERROR;
          acomp_reg <= 1'b0;
          err_reg   <= 1'b1;
        end
      endcase
    end
  end

  assign acomp      = acomp_reg;
  assign err        = err_reg;
  assign word_cnt   = word_cnt_reg;
  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;

endmodule
